// File: rtl/spot_frame_scheduler_pkg.sv
// Shared state encoding and ROI word layout for the ping-pong spot-finder scheduler.
package spot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STREAM = 2'd2
  } sched_state_t;

  localparam int ROI_W   = 40;
  localparam int COORD_W = 10;

  localparam int X_START_LSB = 30;
  localparam int Y_START_LSB = 20;
  localparam int X_END_LSB   = 10;
  localparam int Y_END_LSB   = 0;

  function automatic logic [7:0] clamp_count(input logic [7:0] n, input logic [7:0] max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/spot_frame_scheduler_if.sv
// Valid/ready ROI stream carrying one packed {x_start, y_start, x_end, y_end} word per beat.
interface spot_frame_scheduler_if;

  logic                      roi_valid;
  logic                      roi_ready;
  logic [spot_pkg::ROI_W-1:0] roi_data;
  logic                      roi_last;

  modport master (output roi_valid, output roi_data, output roi_last, input roi_ready);
  modport slave  (input roi_valid, input roi_data, input roi_last, output roi_ready);

endinterface

// File: rtl/spot_frame_scheduler_roi_stream_buffer.sv
// Single-frame ROI result buffer: captures the one-cycle spot-finder result and replays it
// over a registered valid/ready stage.
module roi_stream_buffer
  import spot_pkg::*;
#(
  parameter int NUM_ROIS_MAX = 10
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            i_latch,
  input  logic [7:0]                      i_count,
  input  logic [NUM_ROIS_MAX*ROI_W-1:0]   i_rois,
  output logic                            o_finish,
  output logic                            result_done,
  spot_frame_scheduler_if.master          roi
);

  localparam int IDX_W = (NUM_ROIS_MAX > 1) ? $clog2(NUM_ROIS_MAX) : 1;

  logic [ROI_W-1:0] r_buf [NUM_ROIS_MAX];
  logic [7:0]       r_count;
  logic [7:0]       r_idx;
  logic             r_active;
  logic             r_valid;
  logic             r_last;
  logic             r_done;
  logic [ROI_W-1:0] r_data;
  logic             w_accept;
  logic [7:0]       w_idx_nxt;

  assign w_accept  = r_valid && roi.roi_ready;
  assign w_idx_nxt = r_idx + 8'd1;
  // An empty result finishes on its first active cycle; otherwise on the last accept.
  assign o_finish  = r_active && ((r_count == 8'd0) || (w_accept && r_last));

  always_ff @(posedge clk_in) begin
    if (i_latch) begin
      for (int i = 0; i < NUM_ROIS_MAX; i++) begin
        r_buf[i] <= i_rois[ROI_W*i +: ROI_W];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_active <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_count  <= 8'd0;
      r_idx    <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (i_latch) begin
        r_active <= 1'b1;
        r_count  <= i_count;
        r_idx    <= 8'd0;
        r_valid  <= (i_count != 8'd0);
        r_last   <= (i_count == 8'd1);
        r_data   <= i_rois[ROI_W-1:0];
        r_done   <= (i_count == 8'd0);
      end else if (o_finish) begin
        r_active <= 1'b0;
        r_valid  <= 1'b0;
        r_last   <= 1'b0;
        r_done   <= (r_count != 8'd0);
      end else if (w_accept) begin
        r_idx  <= w_idx_nxt;
        r_data <= r_buf[w_idx_nxt[IDX_W-1:0]];
        r_last <= (w_idx_nxt == (r_count - 8'd1));
      end
    end
  end

  assign roi.roi_valid = r_valid;
  assign roi.roi_data  = r_data;
  assign roi.roi_last  = r_last;
  assign result_done   = r_done;

endmodule

// File: rtl/spot_frame_scheduler.sv
// Ping-pong bank scheduler around main_spot_finder. Optional analysis watchdog is built
// when SPOT_SCHED_WATCHDOG_EN is defined.
module spot_frame_scheduler
  import spot_pkg::*;
#(
  parameter int NUM_ROIS_MAX    = 10,
  parameter int WATCHDOG_CYCLES = 400000
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          frame_done_in,
  output logic                          wr_bank,
  output logic                          rd_bank,
  output logic                          sf_reset,
  input  logic                          sf_analysis_rdy,
  input  logic [7:0]                    sf_num_rois,
  input  logic [NUM_ROIS_MAX*ROI_W-1:0] sf_rois,
  spot_frame_scheduler_if.master        roi,
  output logic                          result_done,
  output logic [7:0]                    frame_id,
  output logic [15:0]                   frames_dropped,
  output logic [7:0]                    watchdog_trips
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;
  logic         r_wr_bank;
  logic         r_rd_bank;
  logic         r_sf_reset;
  logic [1:0]   r_full;
  logic [1:0]   w_full_rel;
  logic [1:0]   w_full_nxt;
  logic         w_wr_bank_nxt;
  logic         w_drop;
  logic [7:0]   r_frame_id;
  logic [15:0]  r_dropped;
  logic         w_latch;
  logic         w_sf_done;
  logic         w_timeout;
  logic         w_finish;
  logic [7:0]   w_latch_count;

  assign w_sf_done = (r_state == RUN) && sf_analysis_rdy;

  always_comb begin
    w_state_nxt   = r_state;
    w_latch       = 1'b0;
    w_latch_count = clamp_count(sf_num_rois, 8'(NUM_ROIS_MAX));
    case (r_state)
      IDLE: begin
        if (r_full[r_rd_bank]) w_state_nxt = RUN;
      end
      RUN: begin
        if (sf_analysis_rdy) begin
          w_latch     = 1'b1;
          w_state_nxt = STREAM;
        end else if (w_timeout) begin
          w_latch       = 1'b1;
          w_latch_count = 8'd0;
          w_state_nxt   = STREAM;
        end
      end
      STREAM: begin
        if (w_finish) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The analysed bank is released before the new frame is judged, so a same-cycle frame is kept.
  always_comb begin
    w_full_rel = r_full;
    if (w_latch) w_full_rel[r_rd_bank] = 1'b0;
    w_full_nxt    = w_full_rel;
    w_wr_bank_nxt = r_wr_bank;
    w_drop        = 1'b0;
    if (frame_done_in) begin
      if (!w_full_rel[r_rd_bank]) begin
        w_full_nxt[r_wr_bank] = 1'b1;
        w_wr_bank_nxt         = ~r_wr_bank;
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sf_reset <= 1'b1;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b1;
      r_full     <= 2'b00;
      r_frame_id <= 8'd0;
      r_dropped  <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_sf_reset <= (w_state_nxt != RUN);
      r_wr_bank  <= w_wr_bank_nxt;
      r_rd_bank  <= ~w_wr_bank_nxt;
      r_full     <= w_full_nxt;
      if (w_sf_done) r_frame_id <= r_frame_id + 8'd1;
      if (w_drop && (r_dropped != 16'hFFFF)) r_dropped <= r_dropped + 16'd1;
    end
  end

`ifdef SPOT_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic [7:0]      r_wd_trips;

  assign w_timeout = (r_state == RUN) && (r_wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_wd_cnt   <= '0;
      r_wd_trips <= 8'd0;
    end else begin
      if ((r_state == RUN) && !sf_analysis_rdy) r_wd_cnt <= r_wd_cnt + 1'b1;
      else                                      r_wd_cnt <= '0;
      if (w_timeout && !sf_analysis_rdy && (r_wd_trips != 8'hFF)) r_wd_trips <= r_wd_trips + 8'd1;
    end
  end

  assign watchdog_trips = r_wd_trips;
`else
  assign w_timeout      = 1'b0;
  assign watchdog_trips = 8'd0;
`endif

  roi_stream_buffer #(
    .NUM_ROIS_MAX (NUM_ROIS_MAX)
  ) u_roi_buf (
    .clk_in      (clk_in),
    .reset       (reset),
    .i_latch     (w_latch),
    .i_count     (w_latch_count),
    .i_rois      (sf_rois),
    .o_finish    (w_finish),
    .result_done (result_done),
    .roi         (roi)
  );

  assign wr_bank        = r_wr_bank;
  assign rd_bank        = r_rd_bank;
  assign sf_reset       = r_sf_reset;
  assign frame_id       = r_frame_id;
  assign frames_dropped = r_dropped;

endmodule

// File: tb/tb_spot_frame_scheduler.sv
// Bench for spot_frame_scheduler: table of single-frame vectors plus hand-written corner
// sequences; ROI words are checked through a scoreboard queue.
module tb_spot_frame_scheduler;
  import spot_pkg::*;

  localparam int NMAX = 10;
  localparam int WD   = 100;

  logic                  clk_in = 1'b0;
  logic                  reset;
  logic                  frame_done_in;
  logic                  wr_bank, rd_bank, sf_reset;
  logic                  sf_analysis_rdy;
  logic [7:0]            sf_num_rois;
  logic [NMAX*ROI_W-1:0] sf_rois;
  logic                  result_done;
  logic [7:0]            frame_id, watchdog_trips;
  logic [15:0]           frames_dropped;

  spot_frame_scheduler_if roi_if ();

  spot_frame_scheduler #(
    .NUM_ROIS_MAX    (NMAX),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .frame_done_in   (frame_done_in),
    .wr_bank         (wr_bank),
    .rd_bank         (rd_bank),
    .sf_reset        (sf_reset),
    .sf_analysis_rdy (sf_analysis_rdy),
    .sf_num_rois     (sf_num_rois),
    .sf_rois         (sf_rois),
    .roi             (roi_if),
    .result_done     (result_done),
    .frame_id        (frame_id),
    .frames_dropped  (frames_dropped),
    .watchdog_trips  (watchdog_trips)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [ROI_W-1:0] data;
    logic             last;
  } exp_t;

  typedef struct {
    int n_rois;
    int delay;
    int rmode;
    int exp_words;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   n_words  = 0;
  int   mode     = 0;
  int   exp_fid  = 0;
  int   exp_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_in);
  endtask

  function automatic logic [ROI_W-1:0] make_roi();
    logic [ROI_W-1:0]   w;
    logic [COORD_W-1:0] x, y;
    x = COORD_W'($urandom_range(0, 1000));
    y = COORD_W'($urandom_range(0, 1000));
    w = '0;
    w[X_START_LSB +: COORD_W] = x;
    w[Y_START_LSB +: COORD_W] = y;
    w[X_END_LSB   +: COORD_W] = x + 10'd7;
    w[Y_END_LSB   +: COORD_W] = y + 10'd3;
    return w;
  endfunction

  // Downstream ready: 0 always, 1 five-cycle stall after two beats, 2 random, 3 never.
  initial begin
    int vcyc;
    vcyc = 0;
    roi_if.roi_ready = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      if (!roi_if.roi_valid) vcyc = 0;
      case (mode)
        0:       roi_if.roi_ready = 1'b1;
        1:       roi_if.roi_ready = !(vcyc >= 2 && vcyc < 7);
        2:       roi_if.roi_ready = 1'($urandom_range(0, 1));
        default: roi_if.roi_ready = 1'b0;
      endcase
      if (roi_if.roi_valid) vcyc++;
    end
  end

  // Output monitor: scoreboard pop on every accept, hold check on every stall.
  initial begin
    logic             prev_stall;
    logic [ROI_W-1:0] prev_data;
    logic             prev_last;
    exp_t             e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk_in);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (result_done) n_done++;
        if (prev_stall) begin
          check("hold_valid", roi_if.roi_valid, 1'b1);
          check("hold_data", roi_if.roi_data, prev_data);
          check("hold_last", roi_if.roi_last, prev_last);
        end
        if (roi_if.roi_valid && roi_if.roi_ready) begin
          n_words++;
          check("word_expected", sb_q.size() != 0, 1'b1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("roi_data", roi_if.roi_data, e.data);
            check("roi_last", roi_if.roi_last, e.last);
          end
        end
        prev_stall = roi_if.roi_valid && !roi_if.roi_ready;
        prev_data  = roi_if.roi_data;
        prev_last  = roi_if.roi_last;
      end
    end
  end

  // Spot-finder model: waits for release, then issues a one-cycle result.
  task automatic sf_respond(input int n, input int delay, input bit fd_same);
    int   waited;
    int   cnt;
    exp_t e;
    waited = 0;
    while (sf_reset !== 1'b0 && waited < 200) begin
      tick();
      waited++;
    end
    check("sf_released", sf_reset, 1'b0);
    if (sf_reset !== 1'b0) return;
    repeat (delay) tick();
    cnt = (n > NMAX) ? NMAX : n;
    for (int i = 0; i < NMAX; i++) sf_rois[ROI_W*i +: ROI_W] = make_roi();
    for (int i = 0; i < cnt; i++) begin
      e.data = sf_rois[ROI_W*i +: ROI_W];
      e.last = (i == cnt - 1);
      sb_q.push_back(e);
    end
    sf_num_rois     = 8'(n);
    sf_analysis_rdy = 1'b1;
    if (fd_same) frame_done_in = 1'b1;
    tick();
    sf_analysis_rdy = 1'b0;
    frame_done_in   = 1'b0;
    sf_num_rois     = 8'hFF;
    for (int i = 0; i < NMAX; i++) sf_rois[ROI_W*i +: ROI_W] = make_roi();
    neg();
    check("sf_reset_after_latch", sf_reset, 1'b1);
    check("valid_after_latch", roi_if.roi_valid, cnt > 0);
    check("done_after_latch", result_done, cnt == 0);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 400) begin
      neg();
      k++;
    end
    check("result_done_seen", n_done >= target, 1'b1);
  endtask

  task automatic run_frame(input int n, input int delay, input int rmode, input int exp_words);
    logic wb;
    int   w0, d0;
    mode = rmode;
    wb   = wr_bank;
    w0   = n_words;
    d0   = n_done;
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    neg();
    check("wr_bank_toggle", wr_bank, !wb);
    check("sf_reset_hold", sf_reset, 1'b1);
    tick();
    neg();
    check("sf_reset_run", sf_reset, 1'b0);
    check("rd_bank", rd_bank, wb);
    sf_respond(n, delay, 1'b0);
    exp_fid = (exp_fid + 1) % 256;
    wait_done(d0 + 1);
    repeat (3) tick();
    neg();
    check("done_once", n_done, d0 + 1);
    check("word_count", n_words - w0, exp_words);
    check("sb_empty", sb_q.size(), 0);
    check("frame_id", frame_id, exp_fid);
    check("frames_dropped", frames_dropped, exp_drop);
    check("idle_sf_reset", sf_reset, 1'b1);
    check("idle_valid", roi_if.roi_valid, 1'b0);
  endtask

  task automatic check_reset_values();
    check("rst_wr_bank", wr_bank, 1'b0);
    check("rst_rd_bank", rd_bank, 1'b1);
    check("rst_sf_reset", sf_reset, 1'b1);
    check("rst_roi_valid", roi_if.roi_valid, 1'b0);
    check("rst_roi_last", roi_if.roi_last, 1'b0);
    check("rst_roi_data", roi_if.roi_data, 0);
    check("rst_result_done", result_done, 1'b0);
    check("rst_frame_id", frame_id, 0);
    check("rst_frames_dropped", frames_dropped, 0);
    check("rst_watchdog_trips", watchdog_trips, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    logic wb;
    int   d0;

    vecs[0] = '{n_rois: 2,  delay: 3, rmode: 0, exp_words: 2};
    vecs[1] = '{n_rois: 0,  delay: 1, rmode: 0, exp_words: 0};
    vecs[2] = '{n_rois: 1,  delay: 0, rmode: 0, exp_words: 1};
    vecs[3] = '{n_rois: 5,  delay: 2, rmode: 1, exp_words: 5};
    vecs[4] = '{n_rois: 12, delay: 4, rmode: 0, exp_words: 10};
    vecs[5] = '{n_rois: 10, delay: 2, rmode: 2, exp_words: 10};

    reset           = 1'b1;
    frame_done_in   = 1'b0;
    sf_analysis_rdy = 1'b0;
    sf_num_rois     = 8'd0;
    sf_rois         = '0;
    repeat (3) tick();
    neg();
    check_reset_values();
    tick();
    reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].n_rois, vecs[v].delay, vecs[v].rmode, vecs[v].exp_words);
    end

    // Extra frame_done pulses while the spot finder is running are dropped.
    mode = 0;
    wb   = wr_bank;
    d0   = n_done;
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    tick();
    neg();
    check("multi_run", sf_reset, 1'b0);
    tick();
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    tick();
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    neg();
    exp_drop += 2;
    check("multi_dropped", frames_dropped, exp_drop);
    check("multi_wr_bank", wr_bank, !wb);
    sf_respond(1, 0, 1'b0);
    exp_fid++;
    wait_done(d0 + 1);
    repeat (2) tick();
    neg();
    check("multi_frame_id", frame_id, exp_fid);
    check("multi_sf_idle", sf_reset, 1'b1);

    // Bank release and frame_done_in in the same cycle: the new frame is kept.
    wb = wr_bank;
    d0 = n_done;
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    tick();
    sf_respond(3, 2, 1'b1);
    exp_fid++;
    check("same_cycle_wr_bank", wr_bank, wb);
    check("same_cycle_dropped", frames_dropped, exp_drop);
    wait_done(d0 + 1);
    sf_respond(2, 1, 1'b0);
    exp_fid++;
    wait_done(d0 + 2);
    repeat (2) tick();
    neg();
    check("same_cycle_frame_id", frame_id, exp_fid);
    check("same_cycle_sb_empty", sb_q.size(), 0);
    check("same_cycle_done_cnt", n_done, d0 + 2);

`ifdef SPOT_SCHED_WATCHDOG_EN
    // Spot finder never answers: watchdog forces an empty result after WD cycles.
    wb = wr_bank;
    d0 = n_done;
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    tick();
    neg();
    check("wd_run", sf_reset, 1'b0);
    repeat (WD - 1) neg();
    check("wd_not_yet", watchdog_trips, 0);
    check("wd_no_done_yet", result_done, 1'b0);
    neg();
    check("wd_trips", watchdog_trips, 1);
    check("wd_result_done", result_done, 1'b1);
    check("wd_sf_reset", sf_reset, 1'b1);
    check("wd_no_valid", roi_if.roi_valid, 1'b0);
    check("wd_frame_id", frame_id, exp_fid);
    tick();
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    neg();
    check("wd_bank_freed", wr_bank, wb);
    check("wd_dropped", frames_dropped, exp_drop);
    sf_respond(1, 0, 1'b0);
    exp_fid++;
    wait_done(d0 + 2);
    repeat (2) tick();
    neg();
    check("wd_after_frame_id", frame_id, exp_fid);
`else
    check("wd_tied_off", watchdog_trips, 0);
`endif

    // Reset in the middle of a stalled stream aborts everything.
    mode = 3;
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    tick();
    sf_respond(6, 0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    neg();
    check_reset_values();
    tick();
    reset = 1'b0;
    sb_q.delete();
    exp_fid  = 0;
    exp_drop = 0;
    tick();
    run_frame(4, 1, 0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spot_frame_scheduler.md
# spot_frame_scheduler

Ping-pong frame-buffer scheduler that places `main_spot_finder` between the camera capture writer and the ROI consumer. It owns the two spot-finder block-RAM banks and steers capture writes and analysis reads to opposite banks. It holds the spot finder in reset until a full frame is available, then starts it. It captures the single-cycle ROI result and streams the ROIs downstream with a valid/ready handshake.

## Interface

Parameters:
- `NUM_ROIS_MAX`, default 10: must match the spot-finder parameter of the same name.
- `WATCHDOG_CYCLES`, default 400000: analysis timeout in cycles. Only used with the watchdog macro.

Ports:
- `clk_in`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_done_in`  in  1  one-cycle pulse. Capture has finished writing bank `wr_bank`.
- `wr_bank`  out  1  bank that capture writes.
- `rd_bank`  out  1  bank that the spot finder reads. Drives the bank-select MSB of `mem_address`.
- `sf_reset`  out  1  drives the spot-finder `reset`. High means the spot finder is held idle.
- `sf_analysis_rdy`  in  1  spot-finder completion strobe.
- `sf_num_rois`  in  8  spot-finder ROI count.
- `sf_rois`  in  NUM_ROIS_MAX*40  packed ROIs. Entry i is `[40*i+:40]` = {x_start, y_start, x_end, y_end}, 10 bits each, x_start in the MSBs.
- `roi_valid`  out  1  ROI word available.
- `roi_ready`  in  1  downstream accepts.
- `roi_data`  out  40  current ROI.
- `roi_last`  out  1  marks the final ROI of the frame.
- `result_done`  out  1  one-cycle pulse when a frame's result is fully delivered.
- `frame_id`  out  8  count of analyzed frames, wraps at 255.
- `frames_dropped`  out  16  saturating count of discarded frames.
- `watchdog_trips`  out  8  saturating count of analysis timeouts.

## Operation

- Each bank has a `full` flag. Capture always writes `wr_bank`; `rd_bank` is always `~wr_bank`.
- On `frame_done_in`:
  - if `full[~wr_bank]`=0: set `full[wr_bank]`=1 and toggle `wr_bank`.
  - otherwise: drop the frame, increment `frames_dropped`, and leave `wr_bank` and the flags unchanged (capture overwrites).
- Release of a bank and `frame_done_in` in the same cycle: the release is evaluated first, so the frame is accepted.

States:
- **IDLE**: `sf_reset`=1. If `full[rd_bank]`, go to RUN.
- **RUN**: `sf_reset`=0. On `sf_analysis_rdy`=1:
  - latch `sf_num_rois` (clamped to NUM_ROIS_MAX) and `sf_rois` into a local buffer in the same cycle; the spot-finder output is valid for exactly that cycle.
  - clear `full[rd_bank]`.
  - assert `sf_reset` from the next cycle.
  - increment `frame_id`.
  - go to STREAM.
- **STREAM**: `sf_reset`=1. Present buffer entry `idx`, starting at 0.
  - `roi_last`=(idx==count-1).
  - Advance `idx` only on `roi_valid && roi_ready`.
  - After the last word is accepted: pulse `result_done` and go to IDLE.
  - If count=0: no `roi_valid`; pulse `result_done` on the first STREAM cycle and go to IDLE.
- `roi_data`, `roi_last`, and the buffer stay stable while `roi_valid && !roi_ready`.
- `roi_valid` never drops without an accept.
- Because the bank is released at the latch, capture can refill it while results stream out. Analysis of the next frame waits for STREAM to finish (single result buffer).

Reset values:
- State IDLE, `sf_reset`=1, `wr_bank`=0, both `full` flags=0.
- `roi_valid`, `roi_last`, `result_done`=0; `roi_data`=0.
- `frame_id`, `frames_dropped`, `watchdog_trips`=0.
- Reset mid-RUN or mid-STREAM aborts immediately. The pending frame and its results are lost and not counted as dropped.

## Timing

- `frame_done_in` in cycle N into a free other bank: `full` is set in N+1. From IDLE, state is RUN and `sf_reset`=0 in N+2.
- Latch on cycle M (`sf_analysis_rdy`): `sf_reset`=1, `roi_valid`=1 (if count>0), and bank free all occur in M+1.
- With `roi_ready` held at 1, one ROI is delivered per cycle. `result_done` is asserted the cycle after the last accept.
- All outputs are registered.

## Configuration

- `SPOT_SCHED_WATCHDOG_EN` defined:
  - RUN counts cycles. If the count reaches `WATCHDOG_CYCLES` without `sf_analysis_rdy`, latch count 0, release the bank, and increment `watchdog_trips`.
  - Then go to STREAM, which pulses `result_done` with no ROIs.
- Not defined: no counter is built, RUN waits indefinitely, and `watchdog_trips` is tied to 0.

## Structure

- Shared package `spot_pkg`:
  - state enum constants IDLE/RUN/STREAM.
  - `ROI_W`=40 and `COORD_W`=10.
  - field offset constants for x_start/y_start/x_end/y_end.
- One sub-module, `roi_stream_buffer`: latch, index counter, and valid/ready output stage. The top level keeps bank ownership and the FSM.

## Test plan

- Single frame, spot finder model returns 2 ROIs, `roi_ready`=1: two words with `roi_last` on the second, `result_done` once, `frame_id`=1, banks toggle 0→1.
- Three `frame_done_in` pulses during one RUN: first accepted, second and third dropped, `frames_dropped`=2, `wr_bank` unchanged after the first.
- `roi_ready` low for 5 cycles mid-stream: `roi_data` stable, no duplicate or lost word.
- 0 ROIs returned: no `roi_valid`, `result_done` pulse one cycle after the latch.
- Bank release and `frame_done_in` in the same cycle: frame accepted, `frames_dropped` unchanged.
- With `SPOT_SCHED_WATCHDOG_EN` and `WATCHDOG_CYCLES`=100, spot finder never ready: in cycle 101 of RUN, `watchdog_trips`=1, `result_done` pulses, bank freed. Separately, `reset` mid-STREAM returns all outputs to reset values next cycle.
